// File: rtl/gpr_writeback.sv
// Writeback stage: merges load returns and ALU results onto the register file write port,
// tracks pending loads and flags operand hazards. Optional forwarding: `define WB_BYPASS_EN.
module gpr_writeback #(
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 4,
    parameter int FIFO_DEPTH = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 alu_valid,
    output logic                 alu_ready,
    input  logic [ADDR_W-1:0]    alu_rd,
    input  logic [DATA_W-1:0]    alu_data,
    input  logic                 ld_issue,
    input  logic [ADDR_W-1:0]    ld_issue_rd,
    input  logic                 ld_valid,
    input  logic [ADDR_W-1:0]    ld_rd,
    input  logic [DATA_W-1:0]    ld_data,
    output logic                 write_en,
    output logic [ADDR_W-1:0]    write_addr,
    output logic [DATA_W-1:0]    write_data,
    output logic [2**ADDR_W-1:0] busy_mask,
    input  logic [ADDR_W-1:0]    rs_addr,
    input  logic [ADDR_W-1:0]    rt_addr,
    output logic                 rs_hazard,
    output logic                 rt_hazard
`ifdef WB_BYPASS_EN
    ,
    output logic                 rs_fwd_valid,
    output logic [DATA_W-1:0]    rs_fwd_data,
    output logic                 rt_fwd_valid,
    output logic [DATA_W-1:0]    rt_fwd_data
`endif
);

    localparam int NREG  = 2**ADDR_W;
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [ADDR_W-1:0] fifo_dest [FIFO_DEPTH];
    logic [DATA_W-1:0] fifo_data [FIFO_DEPTH];
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W-1:0]  wr_ptr;
    logic [CNT_W-1:0]  count;

    logic              fifo_empty;
    logic              fifo_full;
    logic              alu_acc;
    logic              push;
    logic              pop;
    logic              sel_valid;
    logic [ADDR_W-1:0] sel_rd;
    logic [DATA_W-1:0] sel_data;
    logic [NREG-1:0]   busy_next;

    assign fifo_empty = (count == '0);
    assign fifo_full  = (count == CNT_W'(FIFO_DEPTH));
    assign alu_ready  = !fifo_full;
    assign alu_acc    = alu_valid && alu_ready;

    // Source priority: returning load, then oldest queued ALU result, then a fresh ALU result.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first so no latch is inferred.
        sel_valid = 1'b0;
        sel_rd    = '0;
        sel_data  = '0;
        pop       = 1'b0;
        if (ld_valid) begin
            sel_valid = 1'b1;
            sel_rd    = ld_rd;
            sel_data  = ld_data;
        end else if (!fifo_empty) begin
            sel_valid = 1'b1;
            sel_rd    = fifo_dest[rd_ptr];
            sel_data  = fifo_data[rd_ptr];
            pop       = 1'b1;
        end else if (alu_acc) begin
            sel_valid = 1'b1;
            sel_rd    = alu_rd;
            sel_data  = alu_data;
        end
        push = alu_acc && (ld_valid || !fifo_empty);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            if (push && !pop)      count <= count + CNT_W'(1);
            else if (pop && !push) count <= count - CNT_W'(1);
        end
    end

    // NOTE: FIFO storage has no reset; entries are only observed while count marks them valid.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_dest[wr_ptr] <= alu_rd;
            fifo_data[wr_ptr] <= alu_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            write_en   <= 1'b0;
            write_addr <= '0;
            write_data <= '0;
        end else begin
            write_en   <= sel_valid && (sel_rd != '0);
            write_addr <= sel_rd;
            write_data <= sel_data;
        end
    end

    // Clear before set so an issue and return to the same register leaves the new load pending.
    always_comb begin
        busy_next = busy_mask;
        if (ld_valid)
            busy_next[ld_rd] = 1'b0;
        if (ld_issue && (ld_issue_rd != '0))
            busy_next[ld_issue_rd] = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) busy_mask <= '0;
        else     busy_mask <= busy_next;
    end

    logic [ADDR_W-1:0] op_addr [2];
    logic [1:0]        op_hazard;
`ifdef WB_BYPASS_EN
    logic [1:0]        fwd_valid;
    logic [DATA_W-1:0] fwd_data [2];
`endif

    assign op_addr[0] = rs_addr;
    assign op_addr[1] = rt_addr;

    // FIFO scanned oldest to youngest so a later match overrides an earlier one.
    always_comb begin
        for (int p = 0; p < 2; p++) begin
`ifdef WB_BYPASS_EN
            fwd_valid[p] = write_en && (write_addr == op_addr[p]);
            fwd_data[p]  = write_data;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                if (i < int'(count) && fifo_dest[rd_ptr + PTR_W'(i)] == op_addr[p]) begin
                    fwd_valid[p] = 1'b1;
                    fwd_data[p]  = fifo_data[rd_ptr + PTR_W'(i)];
                end
            end
            if (op_addr[p] == '0)
                fwd_valid[p] = 1'b0;
            op_hazard[p] = (op_addr[p] != '0) && busy_mask[op_addr[p]];
`else
            op_hazard[p] = busy_mask[op_addr[p]] || (write_en && (write_addr == op_addr[p]));
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                if (i < int'(count) && fifo_dest[rd_ptr + PTR_W'(i)] == op_addr[p])
                    op_hazard[p] = 1'b1;
            end
            if (op_addr[p] == '0)
                op_hazard[p] = 1'b0;
`endif
        end
    end

    assign rs_hazard = op_hazard[0];
    assign rt_hazard = op_hazard[1];
`ifdef WB_BYPASS_EN
    assign rs_fwd_valid = fwd_valid[0];
    assign rs_fwd_data  = fwd_data[0];
    assign rt_fwd_valid = fwd_valid[1];
    assign rt_fwd_data  = fwd_data[1];
`endif

endmodule

// File: tb/tb_gpr_writeback.sv
// Bench for gpr_writeback: directed vector table, hand-written scoreboard/reset sequences,
// then randomized traffic checked against a queue-based reference model.
module tb_gpr_writeback;

    localparam int DEPTH = 2;

    logic        clk;
    logic        rst;
    logic        alu_valid;
    logic        alu_ready;
    logic [3:0]  alu_rd;
    logic [31:0] alu_data;
    logic        ld_issue;
    logic [3:0]  ld_issue_rd;
    logic        ld_valid;
    logic [3:0]  ld_rd;
    logic [31:0] ld_data;
    logic        write_en;
    logic [3:0]  write_addr;
    logic [31:0] write_data;
    logic [15:0] busy_mask;
    logic [3:0]  rs_addr;
    logic [3:0]  rt_addr;
    logic        rs_hazard;
    logic        rt_hazard;

    gpr_writeback #(.DATA_W(32), .ADDR_W(4), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_data(alu_data),
        .ld_issue(ld_issue), .ld_issue_rd(ld_issue_rd),
        .ld_valid(ld_valid), .ld_rd(ld_rd), .ld_data(ld_data),
        .write_en(write_en), .write_addr(write_addr), .write_data(write_data),
        .busy_mask(busy_mask),
        .rs_addr(rs_addr), .rt_addr(rt_addr), .rs_hazard(rs_hazard), .rt_hazard(rt_hazard)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        av;
        logic [3:0]  ard;
        logic [31:0] ad;
        logic        lv;
        logic [3:0]  lrd;
        logic [31:0] ld;
        logic        li;
        logic [3:0]  lird;
        logic        exp_ready;
        logic        exp_we;
        logic [3:0]  exp_wa;
        logic [31:0] exp_wd;
    } vec_t;

    typedef struct packed {
        logic [3:0]  rd;
        logic [31:0] data;
    } ent_t;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state: queued ALU results, pending loads, current write port.
    ent_t        m_q[$];
    logic [15:0] m_busy;
    logic        m_we;
    logic [3:0]  m_wa;
    logic [31:0] m_wd;
    vec_t        cur;
    vec_t        tbl[15];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(input logic av, input logic [3:0] ard, input logic [31:0] ad,
                                input logic lv, input logic [3:0] lrd, input logic [31:0] ld,
                                input logic li, input logic [3:0] lird,
                                input logic er, input logic ewe, input logic [3:0] ewa,
                                input logic [31:0] ewd);
        vec_t v;
        v.av = av; v.ard = ard; v.ad = ad;
        v.lv = lv; v.lrd = lrd; v.ld = ld;
        v.li = li; v.lird = lird;
        v.exp_ready = er; v.exp_we = ewe; v.exp_wa = ewa; v.exp_wd = ewd;
        return v;
    endfunction

    function automatic logic model_hazard(input logic [3:0] a);
        if (a == 4'd0) return 1'b0;
        if (m_busy[a]) return 1'b1;
        if (m_we && m_wa == a) return 1'b1;
        foreach (m_q[i]) if (m_q[i].rd == a) return 1'b1;
        return 1'b0;
    endfunction

    task automatic model_reset();
        m_q.delete();
        m_busy = '0;
        m_we   = 1'b0;
        m_wa   = '0;
        m_wd   = '0;
    endtask

    // Drive one cycle's inputs and check the combinational outputs against the model.
    task automatic apply(input vec_t v, input logic [3:0] rs, input logic [3:0] rt);
        alu_valid = v.av; alu_rd = v.ard; alu_data = v.ad;
        ld_valid = v.lv; ld_rd = v.lrd; ld_data = v.ld;
        ld_issue = v.li; ld_issue_rd = v.lird;
        rs_addr = rs; rt_addr = rt;
        cur = v;
        #1;
        check("alu_ready", alu_ready, m_q.size() < DEPTH);
        check("rs_hazard", rs_hazard, model_hazard(rs));
        check("rt_hazard", rt_hazard, model_hazard(rt));
    endtask

    // Advance one clock and check registered outputs against the model.
    task automatic clock();
        ent_t        e;
        logic        sel;
        logic        acc;
        logic [3:0]  srd;
        logic [31:0] sd;
        logic [15:0] nb;
        acc = cur.av && (m_q.size() < DEPTH);
        sel = 1'b0; srd = '0; sd = '0;
        e.rd = cur.ard; e.data = cur.ad;
        if (cur.lv) begin
            sel = 1'b1; srd = cur.lrd; sd = cur.ld;
            if (acc) m_q.push_back(e);
        end else if (m_q.size() > 0) begin
            ent_t h;
            h = m_q.pop_front();
            sel = 1'b1; srd = h.rd; sd = h.data;
            if (acc) m_q.push_back(e);
        end else if (acc) begin
            sel = 1'b1; srd = cur.ard; sd = cur.ad;
        end
        nb = m_busy;
        if (cur.lv) nb[cur.lrd] = 1'b0;
        if (cur.li && cur.lird != 4'd0) nb[cur.lird] = 1'b1;
        @(posedge clk);
        #1;
        m_we = sel && (srd != 4'd0);
        m_wa = srd;
        m_wd = sd;
        m_busy = nb;
        check("write_en", write_en, m_we);
        if (m_we) begin
            check("write_addr", write_addr, m_wa);
            check("write_data", write_data, m_wd);
        end
        check("busy_mask", busy_mask, m_busy);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t idle;
        vec_t v;
        idle = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);

        tbl[0]  = mk(1, 3, 32'h11,  0, 0, 0,        0, 0, 1, 1, 3, 32'h11);
        tbl[1]  = idle;
        tbl[2]  = mk(1, 6, 32'hBB,  1, 5, 32'hAA,   0, 0, 1, 1, 5, 32'hAA);
        tbl[3]  = mk(0, 0, 0,       0, 0, 0,        0, 0, 1, 1, 6, 32'hBB);
        tbl[4]  = idle;
        tbl[5]  = mk(1, 1, 32'h101, 1, 10, 32'hA0,  0, 0, 1, 1, 10, 32'hA0);
        tbl[6]  = mk(1, 2, 32'h102, 1, 11, 32'hA1,  0, 0, 1, 1, 11, 32'hA1);
        tbl[7]  = mk(1, 3, 32'h103, 1, 12, 32'hA2,  0, 0, 0, 1, 12, 32'hA2);
        tbl[8]  = mk(1, 3, 32'h103, 1, 13, 32'hA3,  0, 0, 0, 1, 13, 32'hA3);
        tbl[9]  = mk(1, 3, 32'h103, 0, 0, 0,        0, 0, 0, 1, 1, 32'h101);
        tbl[10] = mk(1, 3, 32'h103, 0, 0, 0,        0, 0, 1, 1, 2, 32'h102);
        tbl[11] = mk(0, 0, 0,       0, 0, 0,        0, 0, 1, 1, 3, 32'h103);
        tbl[12] = idle;
        tbl[13] = mk(1, 0, 32'hFF,  0, 0, 0,        0, 0, 1, 0, 0, 0);
        tbl[14] = idle;

        rst = 1'b1;
        alu_valid = 0; alu_rd = 0; alu_data = 0;
        ld_valid = 0; ld_rd = 0; ld_data = 0;
        ld_issue = 0; ld_issue_rd = 0;
        rs_addr = 0; rt_addr = 0;
        model_reset();
        #3;
        check("reset_write_en", write_en, 1'b0);
        check("reset_write_addr", write_addr, 4'd0);
        check("reset_write_data", write_data, 32'd0);
        check("reset_busy_mask", busy_mask, 16'd0);
        check("reset_alu_ready", alu_ready, 1'b1);
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0;

        for (int i = 0; i < 15; i++) begin
            apply(tbl[i], 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
            check("tbl_alu_ready", alu_ready, tbl[i].exp_ready);
            clock();
            check("tbl_write_en", write_en, tbl[i].exp_we);
            if (tbl[i].exp_we) begin
                check("tbl_write_addr", write_addr, tbl[i].exp_wa);
                check("tbl_write_data", write_data, tbl[i].exp_wd);
            end
        end

        // Load to r7: pending, then returned, hazard held until the write has retired.
        v = idle; v.li = 1; v.lird = 7;
        apply(v, 7, 0);
        check("r7_hazard_before_issue", rs_hazard, 1'b0);
        clock();
        check("r7_busy_set", busy_mask[7], 1'b1);
        v = idle; v.lv = 1; v.lrd = 7; v.ld = 32'h77;
        apply(v, 7, 0);
        check("r7_hazard_pending", rs_hazard, 1'b1);
        clock();
        check("r7_write", {write_en, write_addr, write_data}, {1'b1, 4'd7, 32'h77});
        check("r7_busy_clear", busy_mask[7], 1'b0);
        apply(idle, 7, 7);
        check("r7_hazard_in_write", rs_hazard, 1'b1);
        clock();
        apply(idle, 7, 7);
        check("r7_hazard_retired", rs_hazard, 1'b0);
        clock();

        // Load issue to r0 never marks busy.
        v = idle; v.li = 1; v.lird = 0;
        apply(v, 0, 0);
        clock();
        check("r0_never_busy", busy_mask, 16'd0);

        // Issue and return to r9 in the same cycle while r9 is pending, then async reset.
        v = idle; v.li = 1; v.lird = 9;
        apply(v, 9, 0);
        clock();
        check("r9_busy_set", busy_mask[9], 1'b1);
        v = idle; v.li = 1; v.lird = 9; v.lv = 1; v.lrd = 9; v.ld = 32'h99;
        apply(v, 9, 0);
        clock();
        check("r9_write", {write_en, write_addr, write_data}, {1'b1, 4'd9, 32'h99});
        check("r9_busy_kept", busy_mask[9], 1'b1);
        v = idle; v.av = 1; v.ard = 4; v.ad = 32'h44; v.lv = 1; v.lrd = 2; v.ld = 32'h22;
        apply(v, 9, 4);
        #2 rst = 1'b1;
        #1;
        check("midreset_busy_mask", busy_mask, 16'd0);
        check("midreset_write_en", write_en, 1'b0);
        check("midreset_alu_ready", alu_ready, 1'b1);
        model_reset();
        apply(idle, 0, 0);
        @(posedge clk);
        #1 rst = 1'b0;
        apply(idle, 4, 9);
        clock();
        check("postreset_write_en", write_en, 1'b0);

        // Randomized traffic against the reference model.
        for (int n = 0; n < 600; n++) begin
            v = idle;
            v.av   = ($urandom_range(0, 9) < 6);
            v.ard  = 4'($urandom_range(0, 7));
            v.ad   = $urandom;
            v.lv   = ($urandom_range(0, 9) < 3);
            v.lrd  = 4'($urandom_range(0, 7));
            v.ld   = $urandom;
            v.li   = ($urandom_range(0, 9) < 3);
            v.lird = 4'($urandom_range(0, 7));
            apply(v, 4'($urandom_range(0, 7)), 4'($urandom_range(0, 7)));
            clock();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/gpr_writeback.md
Name: gpr_writeback

Overview:
- Writeback stage directly upstream of the general-purpose register file.
- Merges ALU results and returning load data onto the register file's single write port (write_en / write_addr / write_data).
- Tracks outstanding loads in a per-register scoreboard and reports read-operand hazards to decode.

Parameters:
DATA_W, 32, register data width
ADDR_W, 4, register address width (2**ADDR_W registers)
FIFO_DEPTH, 2, ALU result holding FIFO entries (power of two, >=2)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-high reset
alu_valid  in  1  ALU result offered
alu_ready  out  1  ALU result accepted when alu_valid && alu_ready
alu_rd  in  ADDR_W  ALU destination register
alu_data  in  DATA_W  ALU result
ld_issue  in  1  load issued this cycle; marks ld_issue_rd pending
ld_issue_rd  in  ADDR_W  destination of issued load
ld_valid  in  1  load data returning; no backpressure, always accepted
ld_rd  in  ADDR_W  destination of returning load
ld_data  in  DATA_W  returning load data
write_en  out  1  register file write strobe
write_addr  out  ADDR_W  register file write address
write_data  out  DATA_W  register file write data
busy_mask  out  2**ADDR_W  pending-load scoreboard
rs_addr  in  ADDR_W  decode operand address A
rt_addr  in  ADDR_W  decode operand address B
rs_hazard  out  1  operand A not yet valid in register file
rt_hazard  out  1  operand B not yet valid in register file

Behaviour:
- Reset (async, clk not required): write_en=0, write_addr=0, write_data=0, FIFO empty, busy_mask=0. In-flight FIFO entries and pending loads are discarded.
- alu_ready = !fifo_full, derived from registered count. It reads 1 during and after reset.
- Write port outputs are registered with 1-cycle latency: a source selected in cycle N appears on write_* in cycle N+1 for exactly one cycle.
- Source priority per cycle:
  - ld_valid first.
  - Else FIFO head.
  - Else accepted ALU result directly, bypassing the FIFO when it is empty.
- Accepted ALU result enqueues when ld_valid=1 or the FIFO is non-empty.
  - Push and pop in the same cycle leave the count unchanged.
  - ALU results retire in acceptance order.
- Destination 0 is hardwired constant:
  - Any selected write with rd=0 still consumes its slot, but write_en stays 0.
  - A load issued to rd=0 never sets busy.
- Scoreboard:
  - busy[ld_issue_rd] is set on ld_issue.
  - busy[ld_rd] is cleared when ld_valid is taken.
  - Issue and return to the same rd in the same cycle: busy stays set (new load outstanding).
  - ld_valid for a non-busy rd is still written; the bit stays clear.
- Hazards are combinational from registered state:
  - rs_hazard = busy[rs_addr] | any valid FIFO entry with rd==rs_addr | (write_en && write_addr==rs_addr). rt_hazard is identical with rt_addr.
  - rs_addr=0 and rt_addr=0 never raise a hazard.
- WAW ordering between a pending load and an ALU result to the same rd is the issue logic's responsibility; this block must still not drop or reorder either write.
- FIFO pointers wrap modulo FIFO_DEPTH. full = count==FIFO_DEPTH; empty = count==0.

Optional Feature:
- Macro: WB_BYPASS_EN.
- Defined:
  - Adds outputs rs_fwd_valid (1), rs_fwd_data (DATA_W), rt_fwd_valid (1), rt_fwd_data (DATA_W).
  - A match against the write_* output register or a FIFO entry forwards that data. The youngest match wins: newest FIFO entry > older FIFO entry > output register.
  - Forwarded matches do not raise hazards; only busy[] raises rs_hazard/rt_hazard.
  - Address 0 is never forwarded.
- Undefined: forwarding ports are absent; hazards are as stated in Behaviour.

Test Plan:
- Reset, then alu_valid rd=3 data=0x11 for one cycle -> next cycle write_en=1, write_addr=3, write_data=0x11; following cycle write_en=0.
- Same cycle ld_valid rd=5 data=0xAA and alu_valid rd=6 data=0xBB -> cycle+1 writes 5/0xAA, cycle+2 writes 6/0xBB.
- ld_valid held 4 cycles, alu_valid held with rd=1,2,3 -> alu_ready drops after 2 accepts; after ld_valid falls, writes appear in order 1,2,3.
- alu_valid rd=0 data=0xFF -> accepted (alu_ready=1), write_en remains 0 on all cycles.
- ld_issue rd=7 -> busy_mask[7]=1 next cycle, rs_addr=7 gives rs_hazard=1; ld_valid rd=7 data=0x77 -> write 7/0x77, busy_mask[7]=0, rs_hazard=0 once the write retires.
- Simultaneous ld_issue rd=9 and ld_valid rd=9 while busy[9]=1 -> write 9 occurs, busy_mask[9] stays 1; assert rst mid-sequence -> busy_mask=0, write_en=0 immediately.
